// File: rtl/rf_pwr_pkg.sv
// Shared definitions for the multi-channel RF power monitor / auto-attenuation block:
// config register map, reset defaults, FSM states and the shared config record.
package rf_pwr_pkg;

    localparam logic [3:0] ADDR_THR_START = 4'd0;
    localparam logic [3:0] ADDR_THR_HI    = 4'd1;
    localparam logic [3:0] ADDR_THR_LO    = 4'd2;
    localparam logic [3:0] ADDR_HIT       = 4'd3;
    localparam logic [3:0] ADDR_START_N   = 4'd4;
    localparam logic [3:0] ADDR_ON_OFF    = 4'd5;
    localparam logic [3:0] ADDR_TRACK_LEN = 4'd6;
    localparam logic [3:0] ADDR_FORCE     = 4'd7;

    localparam logic [15:0] DEF_THR_START = 16'h0190;
    localparam logic [15:0] DEF_THR_HI    = 16'h0230;
    localparam logic [15:0] DEF_THR_LO    = 16'h01D0;
    localparam logic [3:0]  DEF_HIT_HI    = 4'd3;
    localparam logic [3:0]  DEF_HIT_LO    = 4'd10;
    localparam logic [15:0] DEF_START_N   = 16'd3;
    localparam logic [15:0] DEF_ON_N      = 16'd416;
    localparam logic [15:0] DEF_OFF_N     = 16'd416;
    localparam logic [15:0] DEF_TRACK_LEN = 16'd594;

    typedef enum logic {ST_SEEK, ST_TRACK} state_t;

    typedef struct packed {
        logic [15:0] thr_start;
        logic [15:0] thr_hi;
        logic [15:0] thr_lo;
        logic [3:0]  hit_hi;
        logic [3:0]  hit_lo;
        logic [15:0] start_n;
        logic [15:0] on_n;
        logic [15:0] off_n;
        logic [15:0] track_len;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{
        thr_start: DEF_THR_START, thr_hi: DEF_THR_HI, thr_lo: DEF_THR_LO,
        hit_hi: DEF_HIT_HI, hit_lo: DEF_HIT_LO, start_n: DEF_START_N,
        on_n: DEF_ON_N, off_n: DEF_OFF_N, track_len: DEF_TRACK_LEN
    };

    // A zero track length would never close a period, so it behaves as one window.
    function automatic logic [31:0] eff_track_len(input logic [15:0] len);
        return (len == '0) ? 32'd1 : {16'd0, len};
    endfunction

endpackage

// File: rtl/rf_pwr_att_ctrl_if.sv
// Sample strobes and config-write bus feeding rf_pwr_att_ctrl.
interface rf_pwr_att_ctrl_if #(
    parameter int NUM_CH = 2,
    parameter int SAMP_W = 16
);
    logic [NUM_CH-1:0]        samp_vld;
    logic [NUM_CH*SAMP_W-1:0] samp_data;
    logic                     cfg_wr;
    logic [3:0]               cfg_addr;
    logic [31:0]              cfg_wdata;

    modport master (output samp_vld, samp_data, cfg_wr, cfg_addr, cfg_wdata);
    modport slave  (input  samp_vld, samp_data, cfg_wr, cfg_addr, cfg_wdata);
endinterface

// File: rtl/rf_pwr_chan.sv
// One receive channel: sample window, hit counters, seek/track FSM and attenuation state.
// With RF_PWR_PEAK_EN defined, also reports the peak sample of the last TRACK period.
module rf_pwr_chan
    import rf_pwr_pkg::*;
#(
    parameter int SAMP_W    = 16,
    parameter int WIN_LEN   = 12,
    parameter int SEEK_WINS = 5,
    parameter int CNT_W     = 16
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  cfg_t              cfg,
    input  logic              samp_vld,
    input  logic [SAMP_W-1:0] samp_data,
    output logic              att,
    output logic              trk,
    output logic [CNT_W-1:0]  win_cnt
`ifdef RF_PWR_PEAK_EN
    ,
    output logic [SAMP_W-1:0] peak
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [CNT_W-1:0] st_hits_q, st_hits_d, hi_hits_q, hi_hits_d, lo_hits_q, lo_hits_d;
    logic [CNT_W-1:0] wins_q, wins_d, hot_q, hot_d, cold_q, cold_d, idle_q, idle_d;
    logic             att_q, att_d;

    logic             is_start, is_hi, is_lo, close, win_hot, win_cold, period_end;
    logic [31:0]      st_tot, hi_tot, lo_tot, len_eff;
    logic [CNT_W-1:0] hot_inc, cold_inc;

    // A sample meeting both the hi and lo thresholds counts as hi only.
    assign is_start = 32'(samp_data) >= 32'(cfg.thr_start);
    assign is_hi    = 32'(samp_data) >= 32'(cfg.thr_hi);
    assign is_lo    = !is_hi && (32'(samp_data) <= 32'(cfg.thr_lo));
    assign close    = samp_vld && (32'(samp_cnt_q) == 32'(WIN_LEN - 1));

    // Window totals include the closing sample itself.
    assign st_tot   = 32'(st_hits_q) + 32'(is_start);
    assign hi_tot   = 32'(hi_hits_q) + 32'(is_hi);
    assign lo_tot   = 32'(lo_hits_q) + 32'(is_lo);
    assign win_hot  = (state_q == ST_SEEK) ? (st_tot >= 32'(cfg.hit_hi)) : (hi_tot >= 32'(cfg.hit_hi));
    assign win_cold = (state_q == ST_TRACK) && !win_hot && (lo_tot >= 32'(cfg.hit_lo));
    assign hot_inc  = (win_hot && hot_q != '1) ? hot_q + CNT_W'(1) : hot_q;
    assign cold_inc = (win_cold && cold_q != '1) ? cold_q + CNT_W'(1) : cold_q;
    assign len_eff  = eff_track_len(cfg.track_len);
    assign period_end = (state_q == ST_SEEK) ? (32'(wins_q) + 32'd1 >= 32'(SEEK_WINS))
                                             : (32'(wins_q) + 32'd1 >= len_eff);

`ifdef RF_PWR_PEAK_EN
    logic [SAMP_W-1:0] peak_run_q, peak_run_d, peak_q, peak_d, samp_max;
    assign samp_max = (samp_data > peak_run_q) ? samp_data : peak_run_q;
`endif

    always_comb begin
        // NOTE: every next-state value is defaulted to its current value first, so no path can infer a latch.
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        st_hits_d  = st_hits_q;
        hi_hits_d  = hi_hits_q;
        lo_hits_d  = lo_hits_q;
        wins_d     = wins_q;
        hot_d      = hot_q;
        cold_d     = cold_q;
        idle_d     = idle_q;
        att_d      = att_q;
`ifdef RF_PWR_PEAK_EN
        peak_run_d = peak_run_q;
        peak_d     = peak_q;
        if (samp_vld && state_q == ST_TRACK) begin
            if (close && period_end) begin
                peak_d     = samp_max;
                peak_run_d = '0;
            end else begin
                peak_run_d = samp_max;
            end
        end
`endif
        if (close) begin
            samp_cnt_d = '0;
            st_hits_d  = '0;
            hi_hits_d  = '0;
            lo_hits_d  = '0;
            if (!period_end) begin
                wins_d = wins_q + CNT_W'(1);
                hot_d  = hot_inc;
                cold_d = cold_inc;
            end else begin
                wins_d = '0;
                hot_d  = '0;
                cold_d = '0;
                if (state_q == ST_SEEK) begin
                    if (32'(hot_inc) >= 32'(cfg.start_n)) begin
                        state_d = ST_TRACK;
                        idle_d  = '0;
                    end else if (32'(idle_q) + 32'd1 >= len_eff) begin
                        att_d  = 1'b0;
                        idle_d = '0;
                    end else begin
                        idle_d = idle_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_SEEK;
                    if (att_q && 32'(cold_inc) >= 32'(cfg.off_n))
                        att_d = 1'b0;
                    else if (!att_q && 32'(hot_inc) >= 32'(cfg.on_n))
                        att_d = 1'b1;
                end
            end
        end else if (samp_vld) begin
            samp_cnt_d = samp_cnt_q + CNT_W'(1);
            st_hits_d  = st_hits_q + CNT_W'(is_start);
            hi_hits_d  = hi_hits_q + CNT_W'(is_hi);
            lo_hits_d  = lo_hits_q + CNT_W'(is_lo);
        end
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SEEK;
            samp_cnt_q <= '0;
            st_hits_q  <= '0;
            hi_hits_q  <= '0;
            lo_hits_q  <= '0;
            wins_q     <= '0;
            hot_q      <= '0;
            cold_q     <= '0;
            idle_q     <= '0;
            att_q      <= 1'b0;
`ifdef RF_PWR_PEAK_EN
            peak_run_q <= '0;
            peak_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            st_hits_q  <= st_hits_d;
            hi_hits_q  <= hi_hits_d;
            lo_hits_q  <= lo_hits_d;
            wins_q     <= wins_d;
            hot_q      <= hot_d;
            cold_q     <= cold_d;
            idle_q     <= idle_d;
            att_q      <= att_d;
`ifdef RF_PWR_PEAK_EN
            peak_run_q <= peak_run_d;
            peak_q     <= peak_d;
`endif
        end
    end

    assign att     = att_q;
    assign trk     = (state_q == ST_TRACK);
    assign win_cnt = hot_q;
`ifdef RF_PWR_PEAK_EN
    assign peak    = peak_q;
`endif

endmodule

// File: rtl/rf_pwr_att_ctrl.sv
// Multi-channel RF power monitor with per-channel hysteretic auto-attenuation.
// Optional peak_pwr output when RF_PWR_PEAK_EN is defined.
module rf_pwr_att_ctrl
    import rf_pwr_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int SAMP_W    = 16,
    parameter int WIN_LEN   = 12,
    parameter int SEEK_WINS = 5,
    parameter int CNT_W     = 16
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    rf_pwr_att_ctrl_if.slave         bus,
    output logic [NUM_CH-1:0]        att_en,
    output logic [NUM_CH-1:0]        trk_act,
    output logic [NUM_CH*CNT_W-1:0]  win_cnt
`ifdef RF_PWR_PEAK_EN
    ,
    output logic [NUM_CH*SAMP_W-1:0] peak_pwr
`endif
);

    cfg_t              cfg_q;
    logic              force_sel_q;
    logic [NUM_CH-1:0] force_val_q;
    logic [NUM_CH-1:0] att_int;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cfg_q       <= CFG_DEFAULT;
            force_sel_q <= 1'b0;
            force_val_q <= '0;
        end else if (bus.cfg_wr) begin
            case (bus.cfg_addr)
                ADDR_THR_START: cfg_q.thr_start <= bus.cfg_wdata[15:0];
                ADDR_THR_HI:    cfg_q.thr_hi    <= bus.cfg_wdata[15:0];
                ADDR_THR_LO:    cfg_q.thr_lo    <= bus.cfg_wdata[15:0];
                ADDR_HIT: begin
                    cfg_q.hit_hi <= bus.cfg_wdata[19:16];
                    cfg_q.hit_lo <= bus.cfg_wdata[3:0];
                end
                ADDR_START_N:   cfg_q.start_n   <= bus.cfg_wdata[15:0];
                ADDR_ON_OFF: begin
                    cfg_q.on_n  <= bus.cfg_wdata[31:16];
                    cfg_q.off_n <= bus.cfg_wdata[15:0];
                end
                ADDR_TRACK_LEN: cfg_q.track_len <= bus.cfg_wdata[15:0];
                ADDR_FORCE: begin
                    force_sel_q <= bus.cfg_wdata[16];
                    force_val_q <= bus.cfg_wdata[NUM_CH-1:0];
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        rf_pwr_chan #(
            .SAMP_W(SAMP_W), .WIN_LEN(WIN_LEN), .SEEK_WINS(SEEK_WINS), .CNT_W(CNT_W)
        ) u_chan (
            .sys_clk   (sys_clk),
            .rst       (rst),
            .cfg       (cfg_q),
            .samp_vld  (bus.samp_vld[k]),
            .samp_data (bus.samp_data[k*SAMP_W +: SAMP_W]),
            .att       (att_int[k]),
            .trk       (trk_act[k]),
            .win_cnt   (win_cnt[k*CNT_W +: CNT_W])
`ifdef RF_PWR_PEAK_EN
            ,
            .peak      (peak_pwr[k*SAMP_W +: SAMP_W])
`endif
        );
    end

    // Override only the pins; the channel FSMs keep evolving their own attenuation state.
    assign att_en = force_sel_q ? force_val_q : att_int;

endmodule

// File: tb/tb_rf_pwr_att_ctrl.sv
// Self-checking bench for rf_pwr_att_ctrl: window/period queue model, directed phases, random run.
module tb_rf_pwr_att_ctrl;
    import rf_pwr_pkg::*;

    localparam int NUM_CH = 2, SAMP_W = 16, WIN_LEN = 12, SEEK_WINS = 5, CNT_W = 16;

    logic                    sys_clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       att_en, trk_act;
    logic [NUM_CH*CNT_W-1:0] win_cnt;
`ifdef RF_PWR_PEAK_EN
    logic [NUM_CH*SAMP_W-1:0] peak_pwr;
`endif

    rf_pwr_att_ctrl_if #(.NUM_CH(NUM_CH), .SAMP_W(SAMP_W)) bus ();

    rf_pwr_att_ctrl #(
        .NUM_CH(NUM_CH), .SAMP_W(SAMP_W), .WIN_LEN(WIN_LEN), .SEEK_WINS(SEEK_WINS), .CNT_W(CNT_W)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus),
        .att_en  (att_en),
        .trk_act (trk_act),
        .win_cnt (win_cnt)
`ifdef RF_PWR_PEAK_EN
        ,
        .peak_pwr(peak_pwr)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned m_thr_start, m_thr_hi, m_thr_lo, m_hit_hi, m_hit_lo;
    int unsigned m_start_n, m_on_n, m_off_n, m_track_len;
    bit                m_fsel;
    bit [NUM_CH-1:0]   m_fval;
    bit                m_trk [NUM_CH];
    bit                m_att [NUM_CH];
    int unsigned       m_idle[NUM_CH];
    byte               win_q [NUM_CH][$];   // per-sample hit flags: 1=start 2=hi 4=lo
    byte               per_q [NUM_CH][$];   // per-window class: 1=hot 2=cold 0=neither
    int unsigned       m_peak_run[NUM_CH], m_peak[NUM_CH];

    function automatic int unsigned count_of(input byte q[$], input byte mask);
        int unsigned n = 0;
        foreach (q[i]) if ((q[i] & mask) != 0) n++;
        return (n > 32'hFFFF) ? 32'hFFFF : n;
    endfunction

    function automatic int unsigned tl_eff();
        return (m_track_len == 0) ? 1 : m_track_len;
    endfunction

    task automatic model_reset();
        m_thr_start = 'h190; m_thr_hi = 'h230; m_thr_lo = 'h1D0;
        m_hit_hi = 3; m_hit_lo = 10; m_start_n = 3;
        m_on_n = 416; m_off_n = 416; m_track_len = 594;
        m_fsel = 1'b0; m_fval = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_trk[c] = 1'b0; m_att[c] = 1'b0; m_idle[c] = 0;
            win_q[c].delete(); per_q[c].delete();
            m_peak_run[c] = 0; m_peak[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.samp_vld[c]) begin
                int unsigned s = bus.samp_data[c*SAMP_W +: SAMP_W];
                byte f = 0;
                if (s >= m_thr_start) f |= 1;
                if (s >= m_thr_hi) f |= 2;
                else if (s <= m_thr_lo) f |= 4;
                win_q[c].push_back(f);
                if (m_trk[c] && s > m_peak_run[c]) m_peak_run[c] = s;
                if (win_q[c].size() == WIN_LEN) begin
                    int unsigned n_st = count_of(win_q[c], 1);
                    int unsigned n_hi = count_of(win_q[c], 2);
                    int unsigned n_lo = count_of(win_q[c], 4);
                    win_q[c].delete();
                    if (!m_trk[c]) begin
                        per_q[c].push_back((n_st >= m_hit_hi) ? 8'd1 : 8'd0);
                        if (per_q[c].size() >= SEEK_WINS) begin
                            int unsigned nhot = count_of(per_q[c], 1);
                            per_q[c].delete();
                            if (nhot >= m_start_n) begin
                                m_trk[c] = 1'b1; m_idle[c] = 0;
                            end else begin
                                m_idle[c]++;
                                if (m_idle[c] >= tl_eff()) begin m_att[c] = 1'b0; m_idle[c] = 0; end
                            end
                        end
                    end else begin
                        per_q[c].push_back((n_hi >= m_hit_hi) ? 8'd1 : ((n_lo >= m_hit_lo) ? 8'd2 : 8'd0));
                        if (per_q[c].size() >= tl_eff()) begin
                            int unsigned nhot  = count_of(per_q[c], 1);
                            int unsigned ncold = count_of(per_q[c], 2);
                            per_q[c].delete();
                            if (m_att[c] && ncold >= m_off_n) m_att[c] = 1'b0;
                            else if (!m_att[c] && nhot >= m_on_n) m_att[c] = 1'b1;
                            m_trk[c] = 1'b0;
                            m_peak[c] = m_peak_run[c]; m_peak_run[c] = 0;
                        end
                    end
                end
            end
        end
        // Config lands after this cycle's evaluation, so evaluations above used the old values.
        if (bus.cfg_wr) begin
            case (bus.cfg_addr)
                4'd0: m_thr_start = bus.cfg_wdata[15:0];
                4'd1: m_thr_hi    = bus.cfg_wdata[15:0];
                4'd2: m_thr_lo    = bus.cfg_wdata[15:0];
                4'd3: begin m_hit_hi = bus.cfg_wdata[19:16]; m_hit_lo = bus.cfg_wdata[3:0]; end
                4'd4: m_start_n   = bus.cfg_wdata[15:0];
                4'd5: begin m_on_n = bus.cfg_wdata[31:16]; m_off_n = bus.cfg_wdata[15:0]; end
                4'd6: m_track_len = bus.cfg_wdata[15:0];
                4'd7: begin m_fsel = bus.cfg_wdata[16]; m_fval = bus.cfg_wdata[NUM_CH-1:0]; end
                default: ;
            endcase
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sys_clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [NUM_CH-1:0]       ea, et;
        logic [NUM_CH*CNT_W-1:0] ew;
        forever begin
            @(negedge sys_clk);
            if (cmp_en && !rst) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    ea[c] = m_fsel ? m_fval[c] : m_att[c];
                    et[c] = m_trk[c];
                    ew[c*CNT_W +: CNT_W] = CNT_W'(count_of(per_q[c], 1));
                end
                check("att_en", att_en, ea);
                check("trk_act", trk_act, et);
                check("win_cnt", win_cnt, ew);
`ifdef RF_PWR_PEAK_EN
                for (int c = 0; c < NUM_CH; c++)
                    check("peak_pwr", peak_pwr[c*SAMP_W +: SAMP_W], 64'(m_peak[c]));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    // Every call starts and ends on a falling edge and covers exactly one clock.
    task automatic tick(input logic [NUM_CH-1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                        input logic wr = 1'b0, input logic [3:0] a = 4'd0, input logic [31:0] wd = 32'd0);
        bus.samp_vld  = v;
        bus.samp_data = {d1, d0};
        bus.cfg_wr    = wr;
        bus.cfg_addr  = a;
        bus.cfg_wdata = wd;
        @(negedge sys_clk);
        bus.samp_vld  = '0;
        bus.cfg_wr    = 1'b0;
    endtask

    task automatic feed(input int n, input logic [NUM_CH-1:0] v, input logic [15:0] d0, input logic [15:0] d1);
        repeat (n) tick(v, d0, d1);
    endtask

    task automatic wcfg(input logic [3:0] a, input logic [31:0] wd);
        tick('0, 16'd0, 16'd0, 1'b1, a, wd);
    endtask

    function automatic logic [15:0] rnd_samp();
        return ($urandom_range(0, 2) != 0) ? 16'($urandom_range(16'h0100, 16'h0320)) : 16'($urandom);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.samp_vld = '0; bus.samp_data = '0; bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        repeat (2) @(negedge sys_clk);
        check("rst_att_en", att_en, 0);
        check("rst_trk_act", trk_act, 0);
        check("rst_win_cnt", win_cnt, 0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Seek entry: ch0 hot every window, ch1 below thr_start.
        wcfg(ADDR_TRACK_LEN, 32'd4);
        wcfg(ADDR_ON_OFF, {16'd3, 16'd416});
        feed(59, 2'b11, 16'h0200, 16'h0100);
        check("seek_pre_trk", trk_act, 2'b00);
        check("seek_pre_win", win_cnt[15:0], 4);
        feed(1, 2'b11, 16'h0200, 16'h0100);
        check("seek_entry", trk_act, 2'b01);

        // Attenuate on after 4 hot track windows.
        feed(47, 2'b11, 16'h0300, 16'h0100);
        check("att_on_pre", att_en, 2'b00);
        feed(1, 2'b11, 16'h0300, 16'h0100);
        check("att_on", att_en, 2'b01);
        check("att_on_seek", trk_act, 2'b00);

        // Neither-hi-nor-lo samples hold att; lo samples release it.
        feed(60, 2'b01, 16'h0200, 16'h0000);
        wcfg(ADDR_ON_OFF, {16'd3, 16'd2});
        feed(48, 2'b01, 16'h0200, 16'h0000);
        check("att_hold", att_en, 2'b01);
        feed(60, 2'b01, 16'h0200, 16'h0000);
        feed(48, 2'b01, 16'h0100, 16'h0000);
        check("att_off", att_en, 2'b00);

        // Idle timeout after three failed seek periods.
        feed(60, 2'b01, 16'h0200, 16'h0000);
        feed(48, 2'b01, 16'h0300, 16'h0000);
        check("att_on2", att_en, 2'b01);
        wcfg(ADDR_TRACK_LEN, 32'd3);
        feed(120, 2'b01, 16'h0000, 16'h0000);
        check("idle_pre", att_en, 2'b01);
        feed(60, 2'b01, 16'h0000, 16'h0000);
        check("idle_clear", att_en, 2'b00);

        // Force override.
        wcfg(ADDR_FORCE, 32'h0001_0002);
        check("force_on", att_en, 2'b10);
        wcfg(ADDR_FORCE, 32'h0000_0000);
        check("force_off", att_en, 2'b00);

        // thr_hi written on the evaluation cycle: old threshold decides that window.
        wcfg(ADDR_TRACK_LEN, 32'd1);
        wcfg(ADDR_ON_OFF, {16'd1, 16'd2});
        wcfg(ADDR_HIT, 32'h0001_000A);
        feed(60, 2'b01, 16'h0200, 16'h0000);
        check("race_trk", trk_act, 2'b01);
        feed(11, 2'b01, 16'h0200, 16'h0000);
        tick(2'b01, 16'h0240, 16'h0000, 1'b1, ADDR_THR_HI, 32'h0000_0300);
        check("race_old_thr", att_en, 2'b01);
        check("race_exit", trk_act, 2'b00);

        // Asynchronous reset in the middle of a TRACK window.
        feed(60, 2'b01, 16'h0200, 16'h0000);
        feed(5, 2'b01, 16'h0300, 16'h0000);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_att", att_en, 2'b00);
        check("rst_mid_trk", trk_act, 2'b00);
        check("rst_mid_win", win_cnt, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;
        feed(59, 2'b11, 16'h0200, 16'h0100);
        check("rst_restart_pre", trk_act, 2'b00);
        feed(1, 2'b11, 16'h0200, 16'h0100);
        check("rst_restart", trk_act, 2'b01);
        wcfg(ADDR_TRACK_LEN, 32'd2);

        // Randomized run against the model.
        repeat (4000) begin
            logic [NUM_CH-1:0] v;
            logic [3:0]        a;
            logic [31:0]       wd;
            logic              wr;
            for (int c = 0; c < NUM_CH; c++) v[c] = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 39) == 0);
            a  = 4'($urandom_range(0, 15));
            case (a)
                4'd0, 4'd1, 4'd2: wd = 32'($urandom_range(16'h0150, 16'h0300));
                4'd3: wd = {12'h0, 4'($urandom_range(0, 12)), 12'h0, 4'($urandom_range(0, 12))};
                4'd4: wd = 32'($urandom_range(0, 5));
                4'd5: wd = {16'($urandom_range(0, 4)), 16'($urandom_range(0, 4))};
                4'd6: wd = 32'($urandom_range(0, 3));
                4'd7: wd = ($urandom_range(0, 3) == 0) ? {15'd0, 1'b1, 14'd0, 2'($urandom)} : {30'd0, 2'($urandom)};
                default: wd = $urandom;
            endcase
            tick(v, rnd_samp(), rnd_samp(), wr, a, wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_pwr_att_ctrl.md
Name: rf_pwr_att_ctrl

Overview:
- Multi-channel successor to the receive-board power monitor and auto-attenuation logic.
- Consumes ADC power samples (AD7884-class, one strobe per sample) for NUM_CH receive channels.
- Runs per-channel windowed threshold statistics with a seek/track state machine and produces a hysteretic attenuation enable per channel.
- Sits between the SPI power-readback path and the RF front-end attenuator pins. Configured through the UART command decoder's register-write strobe.

Parameters:
- NUM_CH, 2, number of independent receive channels
- SAMP_W, 16, power sample width
- WIN_LEN, 12, samples per evaluation window
- SEEK_WINS, 5, windows per seek decision
- CNT_W, 16, width of window/track counters

Ports:
- sys_clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- samp_vld  in  NUM_CH  one-cycle strobe per channel, sample valid
- samp_data  in  NUM_CH*SAMP_W  packed samples; ch k at [k*SAMP_W +: SAMP_W]
- cfg_wr  in  1  config write strobe
- cfg_addr  in  4  config register index
- cfg_wdata  in  32  config write data
- att_en  out  NUM_CH  attenuation enable per channel
- trk_act  out  NUM_CH  channel is in TRACK state
- win_cnt  out  NUM_CH*CNT_W  packed hot-window count of the current period (debug)

Behaviour:
- Reset: sys_clk domain, rst asynchronous active-high. att_en=0, trk_act=0, win_cnt=0, all counters 0, FSM=SEEK, config registers at defaults.
- Config registers (shared by all channels; write takes effect the cycle after cfg_wr):
  - 0: thr_start[15:0], default 0x0190
  - 1: thr_hi, default 0x0230
  - 2: thr_lo, default 0x01D0
  - 3: hit_hi[19:16] / hit_lo[3:0], defaults 3 / 10
  - 4: start_n, default 3
  - 5: on_n[31:16] / off_n[15:0], defaults 416 / 416
  - 6: track_len, default 594
  - 7: force_sel[16] / force_val[NUM_CH-1:0]
  - Unused addresses are ignored.
- Sample compare: unsigned. Hit conditions: sample>=thr_start, >=thr_hi, <=thr_lo. A sample that meets both hi and lo counts as hi only.
- Window: per-channel sample counter 0..WIN_LEN-1.
  - The strobe that brings the count to WIN_LEN closes the window, and that sample is included.
  - Window hit counters clear on the cycle after close.
  - A strobe arriving on the close cycle starts the new window.
- SEEK:
  - A window is hot if start-hits >= hit_hi.
  - After SEEK_WINS windows: if hot windows >= start_n, go to TRACK and clear the idle count. Otherwise idle_cnt += 1.
  - When idle_cnt reaches track_len: att_en clears and idle_cnt clears.
- TRACK:
  - A window is hot if hi-hits >= hit_hi; otherwise it is cold if lo-hits >= hit_lo.
  - Hot and cold counts saturate at all-ones.
  - After track_len windows, evaluate:
    - att=1 and cold>=off_n -> att=0.
    - att=0 and hot>=on_n -> att=1.
    - Otherwise att holds.
  - Then return to SEEK and clear the counters. att_en updates 1 cycle after the closing strobe.
- Config write in the same cycle as an evaluation: the evaluation uses the old value.
- track_len=0 is treated as 1.
- Counters never wrap.
- force_sel=1: att_en=force_val combinationally; the FSM keeps running on internal att state.
- Channels are fully independent. Simultaneous strobes on all channels are handled in the same cycle.

Optional Feature:
- Macro RF_PWR_PEAK_EN.
- Defined:
  - Adds output peak_pwr (NUM_CH*SAMP_W), the per-channel maximum sample seen during the current TRACK period.
  - Latched at TRACK exit and held until the next TRACK exit. Reset 0.
- Undefined: port and logic absent; no other behavioural change.

Decomposition:
- Package rf_pwr_pkg:
  - cfg address localparams (ADDR_THR_START..ADDR_FORCE).
  - Default threshold constants.
  - FSM state enum {ST_SEEK, ST_TRACK}.
- Sub-module rf_pwr_chan: one channel (window counter, hit counters, FSM, att register), instantiated NUM_CH times by generate. The top holds config registers and the force mux.

Test Plan:
- Reset defaults: assert rst mid-TRACK -> att_en=0, trk_act=0, registers read back to defaults; first window restarts from sample 0.
- Seek entry: ch0 receives 60 samples of 0x0200 (>=0x0190) -> trk_act[0]=1 after the 5th window's close strobe; ch1 with 0x0100 stays in SEEK.
- Attenuate on: track_len=4, on_n=3, ch0 fed 0x0300 for 48 samples -> att_en[0]=1 exactly 1 cycle after the 48th strobe; then SEEK.
- Attenuate off: att=1, track_len=4, off_n=2, samples 0x0100 -> att_en[0]=0 at the end of the track period. Samples 0x0200 (neither hi nor lo) -> att holds 1.
- Idle timeout: att=1, SEEK with all samples 0x0000, track_len=3 -> att_en clears after 3 failed seek periods (15 windows).
- Force/config race: write force_sel=1, force_val=2'b10 -> att_en=2'b10 next cycle. Write thr_hi on an evaluation cycle -> the old threshold is applied to that evaluation.
